debug_ctrl_v2: RTL and testbench

- UART-side command controller between the byte UART (rx/tx done strobes) and the MIPS pipeline.
- Loads instruction memory byte by byte and gates the pipeline clock-enable for continuous or single-step execution.
- Streams PC, register bank and data memory back over UART.
- Generalises the debug path to parametrised word width and memory depths, and adds a PC breakpoint and an executed-cycle counter readout.

---
 rtl/debug_ctrl_v2_pkg.sv | 51 +++++
 rtl/debug_word_serializer.sv | 77 +++++++
 rtl/debug_ctrl_v2.sv | 278 +++++++++++++++++++++++++++
 tb/tb_debug_ctrl_v2.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_ctrl_v2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debug_ctrl_v2_pkg
//  Purpose  : Shared definitions for the UART debug controller: command
//             codes, one-hot FSM state encodings, word-fetch phases and the
//             bytes-per-word helper.
//  Revision : 1.0 - initial release
// ============================================================================
package debug_ctrl_v2_pkg;

    // Host command codes (one byte each)
    localparam logic [7:0] CMD_LOAD_IM   = 8'h01;
    localparam logic [7:0] CMD_RUN       = 8'h02;
    localparam logic [7:0] CMD_STEP_MODE = 8'h03;
    localparam logic [7:0] CMD_RD_RB     = 8'h04;
    localparam logic [7:0] CMD_RD_DM     = 8'h05;
    localparam logic [7:0] CMD_RD_PC     = 8'h06;
    localparam logic [7:0] CMD_STEP      = 8'h07;
    localparam logic [7:0] CMD_SET_BP    = 8'h08;
    localparam logic [7:0] CMD_RD_CNT    = 8'h09;

    // Default word geometry: 32-bit CPU word over an 8-bit UART
    localparam int BYTES_PER_WORD = 32 / 8;

    function automatic int bytes_per_word(input int nb_word, input int nb_byte);
        return nb_word / nb_byte;
    endfunction

    // One-hot controller states; IDLE is bit 0 so reset shows 10'b1
    typedef enum logic [9:0] {
        ST_IDLE      = 10'b00_0000_0001,
        ST_LOAD_IM   = 10'b00_0000_0010,
        ST_RUN       = 10'b00_0000_0100,
        ST_STEP_WAIT = 10'b00_0000_1000,
        ST_STEP_EXEC = 10'b00_0001_0000,
        ST_SEND_PC   = 10'b00_0010_0000,
        ST_SEND_RB   = 10'b00_0100_0000,
        ST_SEND_DM   = 10'b00_1000_0000,
        ST_BP_LOAD   = 10'b01_0000_0000,
        ST_SEND_CNT  = 10'b10_0000_0000
    } state_t;

    // Per-word fetch sequence inside a send state
    typedef enum logic [1:0] {
        PH_ADDR = 2'd0,   // read address presented
        PH_CAP  = 2'd1,   // read data valid, hand word to serializer
        PH_WAIT = 2'd2    // wait for the serializer to finish the word
    } phase_t;

endpackage : debug_ctrl_v2_pkg
`default_nettype wire

// File: rtl/debug_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : debug_word_serializer
//  Purpose  : Splits a DWORD into BYTE-wide UART transmit requests, least
//             significant byte first. The first byte is requested the cycle
//             after i_load; each later byte the cycle after i_tx_done.
//  Ports    : i_clock, i_reset   - clock, synchronous active-high reset
//             i_load, i_word     - word load strobe and word to send
//             i_tx_done          - UART finished the previous byte
//             o_tx_start         - 1-cycle transmit request
//             o_tx_data          - byte to send, held until the next request
//             o_done             - 1-cycle pulse after the last byte is sent
//  Revision : 1.0 - initial release
// ============================================================================
module debug_word_serializer
    import debug_ctrl_v2_pkg::*;
#(
    parameter int BYTE  = 8,
    parameter int DWORD = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [DWORD-1:0] i_word,
    input  logic             i_tx_done,
    output logic             o_tx_start,
    output logic [BYTE-1:0]  o_tx_data,
    output logic             o_done
);

    localparam int c_BPW = bytes_per_word(DWORD, BYTE);
    localparam int c_CW  = (c_BPW > 1) ? $clog2(c_BPW) : 1;

    logic [DWORD-1:0] r_shift;
    logic [c_CW-1:0]  r_left;     // bytes still to send after the current one
    logic             r_busy;
    logic             r_start;
    logic             r_done;
    logic [BYTE-1:0]  r_data;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift <= '0;
            r_left  <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            if (i_load) begin
                r_data  <= i_word[BYTE-1:0];
                r_shift <= i_word >> BYTE;
                r_left  <= c_CW'(c_BPW - 1);
                r_start <= 1'b1;
                r_busy  <= 1'b1;
            end else if (r_busy && i_tx_done) begin
                if (r_left == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_data  <= r_shift[BYTE-1:0];
                    r_shift <= r_shift >> BYTE;
                    r_left  <= r_left - c_CW'(1);
                    r_start <= 1'b1;
                end
            end
        end
    end

    assign o_tx_start = r_start;
    assign o_tx_data  = r_data;
    assign o_done     = r_done;

endmodule : debug_word_serializer
`default_nettype wire

// File: rtl/debug_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module   : debug_ctrl_v2
//  Purpose  : UART-side debug controller for the MIPS pipeline. Loads
//             instruction memory byte by byte, gates the pipeline enable for
//             run / single-step with an optional PC breakpoint, and streams
//             PC, register bank, data memory and the executed-cycle counter
//             back over the UART.
//  Ports    : i_clock, i_reset       - clock, synchronous active-high reset
//             i_rx_data, i_rx_done   - received byte and its strobe
//             i_tx_done              - previous transmit byte finished
//             i_hlt, i_pc            - pipeline halt flag and current PC
//             i_rb_data, i_dm_data   - debug read data (1-cycle latency)
//             o_im_wr_en/addr/data   - instruction-memory byte write port
//             o_cpu_en               - pipeline advance enable
//             o_rb_addr, o_dm_addr   - debug read addresses
//             o_tx_data, o_tx_start  - transmit byte and request pulse
//             o_state                - one-hot controller state
//  Revision : 1.0 - initial release
// ============================================================================
module debug_ctrl_v2
    import debug_ctrl_v2_pkg::*;
#(
    parameter int BYTE    = 8,
    parameter int DWORD   = 32,
    parameter int IM_ADDR = 8,
    parameter int RB_ADDR = 5,
    parameter int DM_ADDR = 5,
    parameter int NB_ST   = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [BYTE-1:0]    i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic               i_hlt,
    input  logic [DWORD-1:0]   i_pc,
    input  logic [DWORD-1:0]   i_rb_data,
    input  logic [DWORD-1:0]   i_dm_data,
    output logic               o_im_wr_en,
    output logic [IM_ADDR-1:0] o_im_addr,
    output logic [BYTE-1:0]    o_im_data,
    output logic               o_cpu_en,
    output logic [RB_ADDR-1:0] o_rb_addr,
    output logic [DM_ADDR-1:0] o_dm_addr,
    output logic [BYTE-1:0]    o_tx_data,
    output logic               o_tx_start,
    output logic [NB_ST-1:0]   o_state
);

    localparam int c_BPW = bytes_per_word(DWORD, BYTE);
    localparam int c_BCW = (c_BPW > 1) ? $clog2(c_BPW) : 1;

    state_t             r_state;
    state_t             r_ret;        // state to resume after a dump
    logic               r_full;       // dump covers PC, RB and DM
    phase_t             r_phase;
    logic [IM_ADDR-1:0] r_ld_cnt;
    logic [IM_ADDR-1:0] r_im_addr;
    logic [BYTE-1:0]    r_im_data;
    logic               r_im_wr_en;
    logic [RB_ADDR-1:0] r_rb_addr;
    logic [DM_ADDR-1:0] r_dm_addr;
    logic [DWORD-1:0]   r_bp;
    logic [DWORD-1:0]   r_bp_shift;
    logic [c_BCW-1:0]   r_bp_cnt;
    logic               r_bp_en;
    logic [31:0]        r_cycle_cnt;

    logic               w_bp_hit;
    logic               w_cpu_en;
    logic               w_send;
    logic               w_ser_load;
    logic               w_ser_done;
    logic [DWORD-1:0]   w_ser_word;
    logic [DWORD-1:0]   w_bp_next;

    // Breakpoint is compared against the PC about to be fetched, so the
    // enable is withheld in the very cycle the PC matches.
    assign w_bp_hit = r_bp_en && (i_pc == r_bp);
    assign w_cpu_en = ((r_state == ST_RUN) && !i_hlt && !w_bp_hit) ||
                      ((r_state == ST_STEP_EXEC) && !i_hlt);

    assign w_send = (r_state == ST_SEND_PC) || (r_state == ST_SEND_RB) ||
                    (r_state == ST_SEND_DM) || (r_state == ST_SEND_CNT);
    assign w_ser_load = w_send && (r_phase == PH_CAP);

    // Breakpoint bytes arrive LSB first: shift right, new byte enters on top
    assign w_bp_next = (r_bp_shift >> BYTE) | (DWORD'(i_rx_data) << (DWORD - BYTE));

    always_comb begin
        w_ser_word = '0;
        case (r_state)
            ST_SEND_PC:  w_ser_word = i_pc;
            ST_SEND_RB:  w_ser_word = i_rb_data;
            ST_SEND_DM:  w_ser_word = i_dm_data;
            ST_SEND_CNT: w_ser_word = DWORD'(r_cycle_cnt);
            default:     w_ser_word = '0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_ret       <= ST_IDLE;
            r_full      <= 1'b0;
            r_phase     <= PH_ADDR;
            r_ld_cnt    <= '0;
            r_im_addr   <= '0;
            r_im_data   <= '0;
            r_im_wr_en  <= 1'b0;
            r_rb_addr   <= '0;
            r_dm_addr   <= '0;
            r_bp        <= '0;
            r_bp_shift  <= '0;
            r_bp_cnt    <= '0;
            r_bp_en     <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_im_wr_en <= 1'b0;
            // Address advances after each write pulse, wrapping to 0 after
            // the last byte of a full load.
            if (r_im_wr_en) begin
                r_im_addr <= r_im_addr + IM_ADDR'(1);
            end
            if (w_cpu_en) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end

            case (r_state)
                ST_IDLE, ST_STEP_WAIT: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            BYTE'(CMD_LOAD_IM): begin
                                r_state   <= ST_LOAD_IM;
                                r_ld_cnt  <= '0;
                                r_im_addr <= '0;
                            end
                            BYTE'(CMD_RUN):       r_state <= ST_RUN;
                            BYTE'(CMD_STEP_MODE): r_state <= ST_STEP_WAIT;
                            BYTE'(CMD_STEP): begin
                                if (r_state == ST_STEP_WAIT) begin
                                    r_state <= ST_STEP_EXEC;
                                end
                            end
                            BYTE'(CMD_RD_RB): begin
                                r_state <= ST_SEND_RB;
                                r_ret   <= r_state;
                                r_full  <= 1'b0;
                                r_phase <= PH_ADDR;
                            end
                            BYTE'(CMD_RD_DM): begin
                                r_state <= ST_SEND_DM;
                                r_ret   <= r_state;
                                r_full  <= 1'b0;
                                r_phase <= PH_ADDR;
                            end
                            BYTE'(CMD_RD_PC): begin
                                r_state <= ST_SEND_PC;
                                r_ret   <= r_state;
                                r_full  <= 1'b0;
                                r_phase <= PH_ADDR;
                            end
                            BYTE'(CMD_SET_BP): begin
                                r_state  <= ST_BP_LOAD;
                                r_bp_cnt <= '0;
                            end
                            BYTE'(CMD_RD_CNT): begin
                                r_state <= ST_SEND_CNT;
                                r_ret   <= r_state;
                                r_full  <= 1'b0;
                                r_phase <= PH_ADDR;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_LOAD_IM: begin
                    if (i_rx_done) begin
                        r_im_wr_en <= 1'b1;
                        r_im_data  <= i_rx_data;
                        r_ld_cnt   <= r_ld_cnt + IM_ADDR'(1);
                        if (&r_ld_cnt) begin
                            r_state     <= ST_IDLE;
                            r_cycle_cnt <= '0;
                        end
                    end
                end

                ST_RUN: begin
                    if (i_hlt || w_bp_hit) begin
                        r_state <= ST_SEND_PC;
                        r_ret   <= ST_IDLE;
                        r_full  <= 1'b1;
                        r_phase <= PH_ADDR;
                    end
                end

                ST_STEP_EXEC: begin
                    r_state <= ST_SEND_PC;
                    r_ret   <= ST_STEP_WAIT;
                    r_full  <= 1'b1;
                    r_phase <= PH_ADDR;
                end

                ST_BP_LOAD: begin
                    if (i_rx_done) begin
                        r_bp_shift <= w_bp_next;
                        r_bp_cnt   <= r_bp_cnt + c_BCW'(1);
                        if (r_bp_cnt == c_BCW'(c_BPW - 1)) begin
                            r_bp    <= w_bp_next;
                            r_bp_en <= (w_bp_next != '1);   // all-ones disables
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_SEND_PC, ST_SEND_RB, ST_SEND_DM, ST_SEND_CNT: begin
                    case (r_phase)
                        PH_ADDR: r_phase <= PH_CAP;
                        PH_CAP:  r_phase <= PH_WAIT;
                        PH_WAIT: begin
                            if (w_ser_done) begin
                                r_phase <= PH_ADDR;
                                case (r_state)
                                    ST_SEND_PC: begin
                                        r_state <= r_full ? ST_SEND_RB : r_ret;
                                    end
                                    ST_SEND_RB: begin
                                        r_rb_addr <= r_rb_addr + RB_ADDR'(1);
                                        if (&r_rb_addr) begin
                                            r_state <= r_full ? ST_SEND_DM : r_ret;
                                        end
                                    end
                                    ST_SEND_DM: begin
                                        r_dm_addr <= r_dm_addr + DM_ADDR'(1);
                                        if (&r_dm_addr) begin
                                            r_state <= r_ret;
                                        end
                                    end
                                    default: r_state <= r_ret;
                                endcase
                            end
                        end
                        default: r_phase <= PH_ADDR;
                    endcase
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    debug_word_serializer #(
        .BYTE  (BYTE),
        .DWORD (DWORD)
    ) u_ser (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_ser_load),
        .i_word     (w_ser_word),
        .i_tx_done  (i_tx_done),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_done     (w_ser_done)
    );

    assign o_im_wr_en = r_im_wr_en;
    assign o_im_addr  = r_im_addr;
    assign o_im_data  = r_im_data;
    assign o_cpu_en   = w_cpu_en;
    assign o_rb_addr  = r_rb_addr;
    assign o_dm_addr  = r_dm_addr;
    assign o_state    = NB_ST'(r_state);

endmodule : debug_ctrl_v2
`default_nettype wire

// File: tb/tb_debug_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_ctrl_v2
//  Purpose  : Self-checking bench for debug_ctrl_v2 with a small CPU/memory
//             model, a UART tx responder and byte scoreboards.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debug_ctrl_v2;
    import debug_ctrl_v2_pkg::*;

    localparam logic [31:0] c_HALT_PC = 32'h20;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic        i_tx_done;
    logic        i_hlt;
    logic [31:0] i_pc;
    logic [31:0] i_rb_data;
    logic [31:0] i_dm_data;
    logic        o_im_wr_en;
    logic [7:0]  o_im_addr;
    logic [7:0]  o_im_data;
    logic        o_cpu_en;
    logic [4:0]  o_rb_addr;
    logic [4:0]  o_dm_addr;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic [9:0]  o_state;

    always #5 clk = ~clk;

    debug_ctrl_v2 dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_tx_done  (i_tx_done),
        .i_hlt      (i_hlt),
        .i_pc       (i_pc),
        .i_rb_data  (i_rb_data),
        .i_dm_data  (i_dm_data),
        .o_im_wr_en (o_im_wr_en),
        .o_im_addr  (o_im_addr),
        .o_im_data  (o_im_data),
        .o_cpu_en   (o_cpu_en),
        .o_rb_addr  (o_rb_addr),
        .o_dm_addr  (o_dm_addr),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_state    (o_state)
    );

    // ---------------- CPU / memory model ----------------
    logic [31:0] r_pc;
    logic        pc_clr;
    always @(posedge clk) begin
        if (pc_clr)        r_pc <= 32'd0;
        else if (o_cpu_en) r_pc <= r_pc + 32'd4;
    end
    assign i_pc  = r_pc;
    assign i_hlt = (r_pc == c_HALT_PC);

    function automatic logic [31:0] rb_val(input int k);
        return 32'hA5C3_0000 ^ (32'(k) * 32'h0103_0507);
    endfunction
    function automatic logic [31:0] dm_val(input int k);
        return 32'h5A00_F00D + (32'(k) * 32'h1111_0001);
    endfunction

    always @(posedge clk) begin
        i_rb_data <= rb_val(int'(o_rb_addr));
        i_dm_data <= dm_val(int'(o_dm_addr));
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0]  tx_q[$];
    logic [15:0] im_q[$];
    int          tx_seen = 0;
    int          im_wr_cnt = 0;
    int          en_cnt = 0;
    bit          flush = 1'b0;

    // Output monitor: sampled on the falling edge
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (o_cpu_en === 1'b1) en_cnt++;
            if (o_im_wr_en === 1'b1) begin
                im_wr_cnt++;
                if (im_q.size() == 0) check("im_extra_write", 32'(o_im_wr_en), 32'd0);
                else begin
                    e = im_q.pop_front();
                    check("im_addr", 32'(o_im_addr), 32'(e[15:8]));
                    check("im_data", 32'(o_im_data), 32'(e[7:0]));
                end
            end
            if (o_tx_start === 1'b1) begin
                tx_seen++;
                if (tx_q.size() == 0) check("tx_extra_byte", 32'(o_tx_start), 32'd0);
                else check("tx_byte", 32'(o_tx_data), 32'(tx_q.pop_front()));
            end
        end
    end

    // UART tx responder: i_tx_done 80 ns after each o_tx_start
    initial begin
        int cd = 0;
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (flush) cd = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) i_tx_done = 1'b1;
            end
            if (o_tx_start === 1'b1) cd = 8;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] pcv);
        push_word(pcv);
        for (int k = 0; k < 32; k++) push_word(rb_val(k));
        for (int k = 0; k < 32; k++) push_word(dm_val(k));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (tx_q.size() != 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx_q.size()), 32'd0);
        repeat (30) @(negedge clk);
    endtask

    task automatic clear_pc();
        @(negedge clk);
        pc_clr = 1'b1;
        @(negedge clk);
        pc_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int en0;
        int t0;
        int n;
        i_reset   = 1'b1;
        i_rx_data = 8'd0;
        i_rx_done = 1'b0;
        pc_clr    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(o_state), 32'd1);
        check("rst_tx_start", 32'(o_tx_start), 32'd0);
        check("rst_cpu_en", 32'(o_cpu_en), 32'd0);
        check("rst_im_wr", 32'(o_im_wr_en), 32'd0);
        check("rst_addrs", {16'd0, o_im_addr, 3'd0, o_rb_addr}, 32'd0);
        i_reset = 1'b0;
        pc_clr  = 1'b0;

        // Instruction-memory load of 256 bytes
        send_byte(8'h01);
        for (int b = 0; b < 256; b++) begin
            im_q.push_back({8'(b), 8'(b)});
            send_byte(8'(b));
        end
        repeat (5) @(negedge clk);
        check("im_queue_empty", 32'(im_q.size()), 32'd0);
        check("im_write_count", 32'(im_wr_cnt), 32'd256);
        check("load_back_idle", 32'(o_state), 32'd1);
        check("im_addr_wrapped", 32'(o_im_addr), 32'd0);
        send_byte(8'h00);               // 257th byte: must not write
        repeat (5) @(negedge clk);
        check("im_no_257th", 32'(im_wr_cnt), 32'd256);

        // Run to HALT
        en0 = en_cnt;
        t0  = tx_seen;
        push_dump(c_HALT_PC);
        send_byte(8'h02);
        drain("run_dump");
        check("run_en_cycles", 32'(en_cnt - en0), c_HALT_PC / 4);
        check("run_dump_len", 32'(tx_seen - t0), 32'd260);
        check("run_back_idle", 32'(o_state), 32'd1);

        // Breakpoint at 0x10
        clear_pc();
        send_byte(8'h08);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("bp_load_idle", 32'(o_state), 32'd1);
        en0 = en_cnt;
        push_dump(32'h10);
        send_byte(8'h02);
        drain("bp_dump");
        check("bp_en_cycles", 32'(en_cnt - en0), 32'd4);

        // Single steps from a clean counter
        do_reset();
        clear_pc();
        send_byte(8'h03);
        check("step_mode_state", 32'(o_state), 32'(ST_STEP_WAIT));
        for (int s = 1; s <= 2; s++) begin
            en0 = en_cnt;
            t0  = tx_seen;
            push_dump(32'(4 * s));
            send_byte(8'h07);
            drain("step_dump");
            check("step_en_cycles", 32'(en_cnt - en0), 32'd1);
            check("step_dump_len", 32'(tx_seen - t0), 32'd260);
            check("step_back_wait", 32'(o_state), 32'(ST_STEP_WAIT));
        end
        push_word(32'd2);
        send_byte(8'h09);
        drain("cnt_after_steps");
        check("cnt_ret_origin", 32'(o_state), 32'(ST_STEP_WAIT));

        // Reset during a dump, with breakpoint armed and counter non-zero
        send_byte(8'h08);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h03);
        push_dump(32'd12);
        t0 = tx_seen;
        send_byte(8'h07);
        n = 0;
        while ((tx_seen - t0) < 100 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_byte_100", 32'(tx_seen - t0), 32'd100);
        i_reset = 1'b1;
        flush   = 1'b1;
        tx_q.delete();
        @(negedge clk);
        check("abort_tx_start", 32'(o_tx_start), 32'd0);
        check("abort_state", 32'(o_state), 32'd1);
        check("abort_cpu_en", 32'(o_cpu_en), 32'd0);
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        push_word(32'd0);
        send_byte(8'h09);
        drain("cnt_after_reset");
        check("cnt_ret_idle", 32'(o_state), 32'd1);

        // Breakpoint must be gone: run goes all the way to HALT
        clear_pc();
        en0 = en_cnt;
        push_dump(c_HALT_PC);
        send_byte(8'h02);
        drain("run_bp_cleared");
        check("run_bp_cleared_en", 32'(en_cnt - en0), c_HALT_PC / 4);

        // Step while halted: no enable pulse, dump still happens
        send_byte(8'h03);
        en0 = en_cnt;
        t0  = tx_seen;
        push_dump(c_HALT_PC);
        send_byte(8'h07);
        drain("step_halted_dump");
        check("step_halted_no_en", 32'(en_cnt - en0), 32'd0);
        check("step_halted_len", 32'(tx_seen - t0), 32'd260);
        check("step_halted_state", 32'(o_state), 32'(ST_STEP_WAIT));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_debug_ctrl_v2
`default_nettype wire
